// File: rtl/mcu_bus_pkg.sv
// Shared types and constants for the 8051 external-bus to CPLD register bridge.
package mcu_bus_pkg;

  localparam logic [7:0] BASE_P2_DEF = 8'h80;
  // ALE + RD_n + WR_n + P2[7:0] + P0[7:0]
  localparam int         PAD_W       = 19;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_WR_STB  = 3'd2,
    ST_WR_WAIT = 3'd3,
    ST_RD_ACT  = 3'd4,
    ST_SKIP    = 3'd5
  } state_e;

endpackage

// File: rtl/mcu_sync.sv
// Multi-flop synchroniser bank; the async reset loads rst_val_i so each bit
// can come out of reset at its idle pad level.
module mcu_sync #(
  parameter int W     = 1,
  parameter int DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [W-1:0] rst_val_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [DEPTH-1:0][W-1:0] stage_q, stage_d;

  always_comb begin
    stage_d = {stage_q[DEPTH-2:0], d_i};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) stage_q <= {DEPTH{rst_val_i}};
    else          stage_q <= stage_d;
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/mcu_bus_bridge.sv
// 8051 multiplexed external bus to CPLD register-block bridge.
// state      | meaning
// IDLE       | waiting for an ALE falling edge
// ADDR       | address latched, waiting for RD_n/WR_n fall
// WR_STB     | one-clock register write strobe
// WR_WAIT    | write done, waiting for WR_n to return high
// RD_ACT     | register read, CPLD drives P0 until RD_n rises
// SKIP       | miss or contention, waiting for strobes to go high
module mcu_bus_bridge
  import mcu_bus_pkg::*;
#(
  parameter logic [7:0] BASE_P2     = BASE_P2_DEF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       mcu_ale_i,
  input  logic       mcu_rd_n_i,
  input  logic       mcu_wr_n_i,
  input  logic [7:0] mcu_p2_i8,
  input  logic [7:0] mcu_p0_i8,
  output logic [7:0] mcu_p0_o8,
  output logic       mcu_p0_oe_o,
  output logic       reg_cs_o,
  output logic       reg_wr_o,
  output logic       reg_rd_o,
  output logic [7:0] reg_addr_o8,
  output logic [7:0] reg_wrdat_o8,
  input  logic [7:0] reg_rddat_i8,
  output logic       bus_err_o
);

  localparam logic [PAD_W-1:0] PAD_IDLE = {1'b0, 1'b1, 1'b1, 8'h00, 8'h00};

  logic [PAD_W-1:0] pad_s;
  logic             ale_s, rd_s, wr_s;
  logic [7:0]       p2_s, p0_s;

  mcu_sync #(.W(PAD_W), .DEPTH(SYNC_STAGES)) u_sync (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .rst_val_i(PAD_IDLE),
    .d_i      ({mcu_ale_i, mcu_rd_n_i, mcu_wr_n_i, mcu_p2_i8, mcu_p0_i8}),
    .q_o      (pad_s)
  );

  assign {ale_s, rd_s, wr_s, p2_s, p0_s} = pad_s;

  state_e     state_q, state_d;
  logic       ale_prev_q, rd_prev_q, wr_prev_q;
  logic       hit_q, hit_d, err_q, err_d;
  logic [7:0] addr_q, addr_d, wrdat_q, wrdat_d, p0_o_q;
  logic       ale_fall, rd_fall, wr_fall;

  assign ale_fall = ale_prev_q & ~ale_s;
  assign rd_fall  = rd_prev_q  & ~rd_s;
  assign wr_fall  = wr_prev_q  & ~wr_s;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      ale_prev_q <= 1'b0;
      rd_prev_q  <= 1'b1;
      wr_prev_q  <= 1'b1;
      hit_q      <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= 8'h00;
      wrdat_q    <= 8'h00;
      p0_o_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      ale_prev_q <= ale_s;
      rd_prev_q  <= rd_s;
      wr_prev_q  <= wr_s;
      hit_q      <= hit_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      wrdat_q    <= wrdat_d;
      p0_o_q     <= reg_rddat_i8;
    end
  end

  always_comb begin
    state_d = state_q;
    hit_d   = hit_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wrdat_d = wrdat_q;
    // Contention overrides everything, including an in-flight read.
    if (!rd_s && !wr_s) begin
      err_d   = 1'b1;
      state_d = ST_SKIP;
    end else begin
      case (state_q)
        ST_IDLE, ST_ADDR: begin
          if (ale_fall) begin
            addr_d  = p0_s;
            hit_d   = (p2_s == BASE_P2);
            state_d = ST_ADDR;
          end else if (state_q == ST_ADDR && wr_fall) begin
            wrdat_d = p0_s;
            state_d = hit_q ? ST_WR_STB : ST_SKIP;
          end else if (state_q == ST_ADDR && rd_fall) begin
            state_d = hit_q ? ST_RD_ACT : ST_SKIP;
          end
        end
        ST_WR_STB:  state_d = ST_WR_WAIT;
        ST_WR_WAIT: if (wr_s) state_d = ST_IDLE;
        ST_RD_ACT:  if (rd_s) state_d = ST_IDLE;
        ST_SKIP:    if (rd_s && wr_s) state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    reg_wr_o    = (state_q == ST_WR_STB);
    reg_rd_o    = (state_q == ST_RD_ACT);
    reg_cs_o    = reg_wr_o | reg_rd_o;
    mcu_p0_oe_o = reg_rd_o;
  end

  assign mcu_p0_o8    = p0_o_q;
  assign reg_addr_o8  = addr_q;
  assign reg_wrdat_o8 = wrdat_q;
  assign bus_err_o    = err_q;

endmodule

// File: tb/tb_mcu_bus_bridge.sv
// Scoreboard bench for mcu_bus_bridge: drives 8051 bus cycles, checks strobes,
// latencies, miss/contention handling and reset behaviour.
module tb_mcu_bus_bridge;
  import mcu_bus_pkg::*;

  logic       clk_i = 1'b0, rst_n_i = 1'b0;
  logic       mcu_ale_i = 1'b0, mcu_rd_n_i = 1'b1, mcu_wr_n_i = 1'b1;
  logic [7:0] mcu_p2_i8 = 8'h00, mcu_p0_i8 = 8'h00, reg_rddat_i8 = 8'h00;
  logic [7:0] mcu_p0_o8, reg_addr_o8, reg_wrdat_o8;
  logic       mcu_p0_oe_o, reg_cs_o, reg_wr_o, reg_rd_o, bus_err_o;

  mcu_bus_bridge dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .mcu_ale_i   (mcu_ale_i),
    .mcu_rd_n_i  (mcu_rd_n_i),
    .mcu_wr_n_i  (mcu_wr_n_i),
    .mcu_p2_i8   (mcu_p2_i8),
    .mcu_p0_i8   (mcu_p0_i8),
    .mcu_p0_o8   (mcu_p0_o8),
    .mcu_p0_oe_o (mcu_p0_oe_o),
    .reg_cs_o    (reg_cs_o),
    .reg_wr_o    (reg_wr_o),
    .reg_rd_o    (reg_rd_o),
    .reg_addr_o8 (reg_addr_o8),
    .reg_wrdat_o8(reg_wrdat_o8),
    .reg_rddat_i8(reg_rddat_i8),
    .bus_err_o   (bus_err_o)
  );

  always #5 clk_i = ~clk_i;

  int          checks = 0, errors = 0;
  int          wr_pulses = 0, cs_cycles = 0, oe_cycles = 0;
  logic        oe_prev = 1'b0;
  logic [15:0] wr_q[$];
  logic [15:0] rd_q[$];
  logic [15:0] exp_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on each write pulse and read-window start.
  always @(negedge clk_i) begin
    if (rst_n_i) begin
      if (reg_cs_o) cs_cycles++;
      if (mcu_p0_oe_o) begin
        oe_cycles++;
        chk("oe_only_in_read", 32'({reg_cs_o, reg_rd_o, reg_wr_o}), 32'b110);
      end
      if (reg_wr_o) begin
        wr_pulses++;
        chk("wr_expected", 32'(wr_q.size() != 0), 32'd1);
        if (wr_q.size() != 0) begin
          exp_e = wr_q.pop_front();
          chk("wr_addr", 32'(reg_addr_o8), 32'(exp_e[15:8]));
          chk("wr_data", 32'(reg_wrdat_o8), 32'(exp_e[7:0]));
        end
      end
      if (mcu_p0_oe_o && !oe_prev) begin
        chk("rd_expected", 32'(rd_q.size() != 0), 32'd1);
        if (rd_q.size() != 0) begin
          exp_e = rd_q.pop_front();
          chk("rd_addr", 32'(reg_addr_o8), 32'(exp_e[15:8]));
          chk("rd_p0", 32'(mcu_p0_o8), 32'(exp_e[7:0]));
        end
      end
      oe_prev = mcu_p0_oe_o;
    end else begin
      oe_prev = 1'b0;
    end
  end

  task automatic ale_cycle(input logic [7:0] hi, input logic [7:0] lo);
    @(negedge clk_i);
    mcu_p2_i8 = hi; mcu_p0_i8 = lo; mcu_ale_i = 1'b1;
    repeat (2) @(negedge clk_i);
    mcu_ale_i = 1'b0;
    repeat (3) @(negedge clk_i);
  endtask

  task automatic do_write(input logic [7:0] hi, input logic [7:0] addr,
                          input logic [7:0] data, input int gap);
    int first = 0;
    int p0 = wr_pulses;
    ale_cycle(hi, addr);
    if (hi == BASE_P2_DEF) wr_q.push_back({addr, data});
    mcu_p0_i8 = data; mcu_wr_n_i = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk_i); #1;
      if (reg_wr_o && first == 0) first = i;
    end
    @(negedge clk_i);
    mcu_wr_n_i = 1'b1;
    repeat (gap) @(negedge clk_i);
    if (hi == BASE_P2_DEF) begin
      chk("wr_latency", 32'(first), 32'd3);
      chk("wr_pulse_count", 32'(wr_pulses - p0), 32'd1);
    end else begin
      chk("miss_no_wr", 32'(wr_pulses - p0), 32'd0);
    end
  endtask

  task automatic do_read(input logic [7:0] hi, input logic [7:0] addr,
                         input logic [7:0] data, input int gap);
    int first = 0;
    int drop = 0;
    reg_rddat_i8 = data;
    ale_cycle(hi, addr);
    rd_q.push_back({addr, data});
    mcu_rd_n_i = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk_i); #1;
      if (mcu_p0_oe_o && first == 0) first = i;
    end
    @(negedge clk_i);
    mcu_rd_n_i = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk_i); #1;
      if (!mcu_p0_oe_o && drop == 0) drop = i;
    end
    chk("rd_oe_latency", 32'(first), 32'd3);
    chk("rd_oe_drop", 32'(drop), 32'd3);
    repeat (gap) @(negedge clk_i);
  endtask

  initial begin
    int cs0, oe0, got;
    repeat (3) @(negedge clk_i);
    chk("rst_oe", 32'(mcu_p0_oe_o), 32'd0);
    chk("rst_cs", 32'(reg_cs_o), 32'd0);
    chk("rst_addr", 32'(reg_addr_o8), 32'h00);
    chk("rst_p0", 32'(mcu_p0_o8), 32'h00);
    chk("rst_err", 32'(bus_err_o), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    rst_n_i = 1'b1;
    repeat (2) @(negedge clk_i);

    do_write(8'h80, 8'h02, 8'hA5, 4);
    do_read(8'h80, 8'h01, 8'h3C, 4);

    cs0 = cs_cycles;
    do_write(8'h40, 8'h10, 8'hFF, 4);
    chk("miss_no_cs", 32'(cs_cycles - cs0), 32'd0);
    chk("miss_idle", 32'(dut.state_q), 32'(ST_IDLE));

    cs0 = cs_cycles; oe0 = oe_cycles;
    ale_cycle(8'h80, 8'h05);
    mcu_rd_n_i = 1'b0; mcu_wr_n_i = 1'b0;
    repeat (6) @(negedge clk_i);
    chk("cont_err", 32'(bus_err_o), 32'd1);
    chk("cont_no_cs", 32'(cs_cycles - cs0), 32'd0);
    chk("cont_no_oe", 32'(oe_cycles - oe0), 32'd0);
    mcu_rd_n_i = 1'b1; mcu_wr_n_i = 1'b1;
    repeat (4) @(negedge clk_i);
    chk("cont_idle", 32'(dut.state_q), 32'(ST_IDLE));
    chk("err_sticky", 32'(bus_err_o), 32'd1);

    reg_rddat_i8 = 8'h5A;
    ale_cycle(8'h80, 8'h07);
    rd_q.push_back({8'h07, 8'h5A});
    mcu_rd_n_i = 1'b0;
    got = 0;
    for (int i = 0; i < 6 && got == 0; i++) begin
      @(posedge clk_i); #1;
      if (mcu_p0_oe_o) got = 1;
    end
    chk("rstrd_oe_before", 32'(got), 32'd1);
    @(negedge clk_i); #1;
    rst_n_i = 1'b0;
    #1;
    chk("rstrd_oe_now", 32'(mcu_p0_oe_o), 32'd0);
    chk("rstrd_cs_now", 32'(reg_cs_o), 32'd0);
    chk("rstrd_err_clr", 32'(bus_err_o), 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    cs0 = cs_cycles; oe0 = oe_cycles;
    repeat (8) @(negedge clk_i);
    chk("rstrd_no_oe", 32'(oe_cycles - oe0), 32'd0);
    chk("rstrd_no_cs", 32'(cs_cycles - cs0), 32'd0);
    mcu_rd_n_i = 1'b1;
    repeat (4) @(negedge clk_i);
    do_read(8'h80, 8'h09, 8'hC3, 4);

    do_write(8'h80, 8'h11, 8'h6E, 2);
    do_read(8'h80, 8'h12, 8'h81, 2);

    repeat (4) @(negedge clk_i);
    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
    chk("final_err", 32'(bus_err_o), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
